// File: rtl/axi_lite_bus_master_pkg.sv
// Shared definitions for the AXI4-Lite bus master: address-type codes from the
// shared address map, AXI response codes and the transaction FSM state type.
package axi_lite_bus_master_pkg;

    // Address-type codes produced by the CPU bus address converter
    typedef enum logic [2:0] {
        ADDR_NOT_OP       = 3'd0,
        ADDR_AXI          = 3'd1,
        ADDR_INTERNAL_ROM = 3'd2,
        ADDR_INTERNAL_RAM = 3'd3,
        ADDR_INTERNAL_LED = 3'd4,
        ADDR_UNKNOWN      = 3'd7
    } addr_type_t;

    localparam int         RESP_W    = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte returned for anything that did not produce real read data
    localparam logic [7:0] RDATA_LOCAL = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        DONE
    } state_t;

endpackage

// File: rtl/axi_lite_bus_master_if.sv
// AXI4-Lite channel bundle between the bus master and the interconnect.
interface axi_lite_bus_master_if;
    import axi_lite_bus_master_pkg::*;

    logic [31:0]       awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [RESP_W-1:0] bresp;
    logic              bvalid;
    logic              bready;
    logic [31:0]       araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [RESP_W-1:0] rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_lane_shift.sv
// Byte-lane steering: moves a lane-0 write byte/strobe up to the addressed lane
// and pulls the addressed byte down out of a 32-bit read word.
module axi_lite_lane_shift (
    input  logic [1:0]  lane,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] rd_word,
    output logic [31:0] wr_data_sh,
    output logic [3:0]  wr_strb_sh,
    output logic [7:0]  rd_byte
);

    // Pure lane steering; strobe bits shifted past lane 3 are dropped
    always_comb begin
        wr_data_sh = wr_data << {lane, 3'b000};
        wr_strb_sh = wr_strb << lane;
        rd_byte    = rd_word[{lane, 3'b000} +: 8];
    end

endmodule

// File: rtl/axi_lite_bus_master.sv
// Runs one CPU bus request as a single AXI4-Lite transaction, or completes it
// locally for non-AXI address types. Optional build macro AXI_TIMEOUT_EN adds a
// per-transaction watchdog of TIMEOUT_CYCLES cycles.
module axi_lite_bus_master
    import axi_lite_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         req_is_read,
    input  logic [2:0]                   req_addr_type,
    input  logic [31:0]                  req_a32,
    input  logic [31:0]                  req_d32,
    input  logic [3:0]                   req_wstrb,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   rdata,
    output logic                         err,
    axi_lite_bus_master_if.master        m_axi
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [7:0]  rdata_q;
    logic        err_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic        accept;
    logic        is_axi;
    logic        aw_pending;
    logic        w_pending;
    logic        aw_hs;
    logic        w_hs;
    logic        timeout_hit;
    logic [1:0]  shift_lane;
    logic [31:0] wdata_sh;
    logic [3:0]  wstrb_sh;
    logic [7:0]  rd_byte;

    assign accept     = (state_q == IDLE) && req_valid;
    assign is_axi     = (req_addr_type == ADDR_AXI);
    assign aw_pending = (state_q == WR_AW) && !aw_done_q;
    assign w_pending  = (state_q == WR_AW) && !w_done_q;
    assign aw_hs      = aw_pending && m_axi.awready;
    assign w_hs       = w_pending && m_axi.wready;

    // In IDLE the shifter works on the incoming request, afterwards on the latched lane
    assign shift_lane = (state_q == IDLE) ? req_a32[1:0] : lane_q;

    axi_lite_lane_shift u_lane_shift (
        .lane       (shift_lane),
        .wr_data    (req_d32),
        .wr_strb    (req_wstrb),
        .rd_word    (m_axi.rdata),
        .wr_data_sh (wdata_sh),
        .wr_strb_sh (wstrb_sh),
        .rd_byte    (rd_byte)
    );

`ifdef AXI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer_q;
    logic          in_flight;

    assign in_flight   = (state_q == RD_A) || (state_q == RD_D) ||
                         (state_q == WR_AW) || (state_q == WR_B);
    assign timeout_hit = in_flight && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on every accept and counts only while waiting on the bus
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            timer_q <= '0;
        end else if (in_flight) begin
            timer_q <= timer_q + TW'(1);
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // State register; reset abandons any transaction without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a watchdog expiry overrides any pending handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!is_axi) begin
                        state_d = DONE;
                    end else if (req_is_read) begin
                        state_d = RD_A;
                    end else if (req_wstrb != 4'b0000) begin
                        state_d = WR_AW;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RD_A: begin
                if (m_axi.arready) begin
                    state_d = RD_D;
                end
            end
            RD_D: begin
                if (m_axi.rvalid) begin
                    state_d = DONE;
                end
            end
            WR_AW: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                if (m_axi.bvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_d = DONE;
        end
    end

    // Request latch, AW/W completion tracking and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            lane_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            addr_q    <= req_a32;
            lane_q    <= req_a32[1:0];
            wdata_q   <= wdata_sh;
            wstrb_q   <= wstrb_sh;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (!is_axi) begin
                rdata_q <= RDATA_LOCAL;
            end
        end else begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
            if ((state_q == RD_D) && m_axi.rvalid) begin
                rdata_q <= rd_byte;
                err_q   <= (m_axi.rresp != RESP_OKAY);
            end
            if ((state_q == WR_B) && m_axi.bvalid) begin
                err_q <= (m_axi.bresp != RESP_OKAY);
            end
            if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= RDATA_LOCAL;
            end
        end
    end

    assign busy  = (state_q != IDLE) || accept;
    assign done  = (state_q == DONE);
    assign rdata = rdata_q;
    assign err   = err_q;

    assign m_axi.araddr  = addr_q;
    assign m_axi.arvalid = (state_q == RD_A);
    assign m_axi.rready  = (state_q == RD_D);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awvalid = aw_pending;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = w_pending;
    assign m_axi.bready  = (state_q == WR_B);

endmodule

// File: tb/tb_axi_lite_bus_master.sv
// Self-checking bench for axi_lite_bus_master: directed scenarios plus randomized
// transactions against a behavioural model of the expected bus results.
module tb_axi_lite_bus_master;
    import axi_lite_bus_master_pkg::*;

    localparam int TO_CYCLES = 16;
    localparam int BUDGET    = 200;

    typedef struct {
        bit          is_read;
        logic [2:0]  atype;
        logic [31:0] a32;
        logic [31:0] d32;
        logic [3:0]  ws;
        logic [31:0] srdata;
        logic [1:0]  resp;
        int          ar_wait;
        int          r_wait;
        int          aw_wait;
        int          w_wait;
        int          b_wait;
        bit          poke;
    } txn_t;

    typedef struct {
        int          latency;
        bit          traffic;
        bit          check_rdata;
        logic [7:0]  rdata;
        bit          err;
        bit          axi_read;
        bit          axi_write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_is_read;
    logic [2:0]  req_addr_type;
    logic [31:0] req_a32;
    logic [31:0] req_d32;
    logic [3:0]  req_wstrb;
    logic        busy;
    logic        done;
    logic [7:0]  rdata;
    logic        err;

    int total_checks = 0;
    int pass_checks  = 0;
    int fail_checks  = 0;

    int          obs_latency;
    int          proto_err;
    int          b_to_done;
    bit          any_valid;
    logic [7:0]  obs_rdata;
    logic        obs_err;
    logic        obs_err_first;
    logic [31:0] obs_araddr;
    logic [31:0] obs_awaddr;
    logic [31:0] obs_wdata;
    logic [3:0]  obs_wstrb;

    axi_lite_bus_master_if bus ();

    axi_lite_bus_master #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_is_read   (req_is_read),
        .req_addr_type (req_addr_type),
        .req_a32       (req_a32),
        .req_d32       (req_d32),
        .req_wstrb     (req_wstrb),
        .busy          (busy),
        .done          (done),
        .rdata         (rdata),
        .err           (err),
        .m_axi         (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) pass_checks++;
        else begin
            fail_checks++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearSlave();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;
    endtask

    // Reference model: what the bus and the CPU side should see for one request
    function automatic exp_t predict(input txn_t t);
        exp_t        e;
        int          lane;
        logic [63:0] scale;
        int          slowest;
        e = '{default: 0};
        lane  = int'(t.a32 % 4);
        scale = 64'd1 << (8 * lane);
        if (t.atype != ADDR_AXI) begin
            e.latency     = 1;
            e.check_rdata = 1'b1;
            e.rdata       = 8'hFF;
        end else if (t.is_read) begin
            e.latency     = 3 + t.ar_wait + t.r_wait;
            e.traffic     = 1'b1;
            e.check_rdata = 1'b1;
            e.rdata       = 8'((64'(t.srdata) / scale) % 256);
            e.err         = (t.resp != 2'b00);
            e.axi_read    = 1'b1;
        end else if (t.ws == 4'd0) begin
            e.latency = 1;
        end else begin
            slowest     = (t.aw_wait > t.w_wait) ? t.aw_wait : t.w_wait;
            e.latency   = 3 + slowest + t.b_wait;
            e.traffic   = 1'b1;
            e.err       = (t.resp != 2'b00);
            e.axi_write = 1'b1;
            e.wdata     = 32'((64'(t.d32) * scale) % 64'h1_0000_0000);
            e.wstrb     = 4'((int'(t.ws) * (1 << lane)) % 16);
        end
        return e;
    endfunction

    function automatic txn_t mkTxn(input bit is_read, input logic [2:0] atype, input logic [31:0] a32,
                                   input logic [31:0] d32, input logic [3:0] ws,
                                   input logic [31:0] srdata, input logic [1:0] resp);
        txn_t t;
        t = '{default: 0};
        t.is_read = is_read;
        t.atype   = atype;
        t.a32     = a32;
        t.d32     = d32;
        t.ws      = ws;
        t.srdata  = srdata;
        t.resp    = resp;
        return t;
    endfunction

    // Issue one request and play the AXI slave cycle by cycle until done
    task automatic applyStimulus(input txn_t t);
        int ar_seen = 0;
        int r_seen  = 0;
        int aw_seen = 0;
        int w_seen  = 0;
        int b_seen  = 0;
        int b_set   = -1;
        bit ar_pend = 1'b0;
        bit aw_pend = 1'b0;
        bit w_pend  = 1'b0;
        obs_latency   = -1;
        proto_err     = 0;
        b_to_done     = -1;
        any_valid     = 1'b0;
        obs_rdata     = 8'h00;
        obs_err       = 1'b0;
        obs_err_first = 1'b0;
        obs_araddr    = 32'h0;
        obs_awaddr    = 32'h0;
        obs_wdata     = 32'h0;
        obs_wstrb     = 4'h0;
        @(negedge clk);
        req_is_read   = t.is_read;
        req_addr_type = t.atype;
        req_a32       = t.a32;
        req_d32       = t.d32;
        req_wstrb     = t.ws;
        req_valid     = 1'b1;
        #1;
        if (busy !== 1'b1) proto_err++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge clk);
            if (t.poke) begin
                req_valid     = (cyc == 1);
                req_addr_type = ADDR_UNKNOWN;
            end
            if (cyc == 1) obs_err_first = err;
            if (busy !== 1'b1) proto_err++;
            if ((ar_pend && !bus.arvalid) || (aw_pend && !bus.awvalid) || (w_pend && !bus.wvalid)) proto_err++;
            any_valid = any_valid | bus.arvalid | bus.awvalid | bus.wvalid;
            if (done === 1'b1) begin
                obs_latency = cyc;
                obs_rdata   = rdata;
                obs_err     = err;
                if (b_set >= 0) b_to_done = cyc - b_set;
                break;
            end
            bus.arready = bus.arvalid && (ar_seen >= t.ar_wait);
            if (bus.arvalid) ar_seen++;
            if (bus.arvalid && bus.arready) obs_araddr = bus.araddr;
            ar_pend = bus.arvalid && !bus.arready;
            bus.rvalid = bus.rready && (r_seen >= t.r_wait);
            bus.rdata  = bus.rvalid ? t.srdata : 32'h0;
            bus.rresp  = bus.rvalid ? t.resp : 2'b00;
            if (bus.rready) r_seen++;
            bus.awready = bus.awvalid && (aw_seen >= t.aw_wait);
            if (bus.awvalid) aw_seen++;
            if (bus.awvalid && bus.awready) obs_awaddr = bus.awaddr;
            aw_pend = bus.awvalid && !bus.awready;
            bus.wready = bus.wvalid && (w_seen >= t.w_wait);
            if (bus.wvalid) w_seen++;
            if (bus.wvalid && bus.wready) begin
                obs_wdata = bus.wdata;
                obs_wstrb = bus.wstrb;
            end
            w_pend = bus.wvalid && !bus.wready;
            bus.bvalid = bus.bready && (b_seen >= t.b_wait);
            bus.bresp  = bus.bvalid ? t.resp : 2'b00;
            if (bus.bready) b_seen++;
            if (bus.bvalid && (b_set < 0)) b_set = cyc;
        end
        req_valid = 1'b0;
        clearSlave();
        if (obs_latency >= 0) begin
            @(negedge clk);
            if ((done !== 1'b0) || (busy !== 1'b0)) proto_err++;
        end
    endtask

    // Run one request and compare everything observable against the model
    task automatic runTransaction(input txn_t t, input string tag);
        exp_t e;
        e = predict(t);
        applyStimulus(t);
        checkOutput({tag, ".latency"}, 32'(obs_latency), 32'(e.latency));
        checkOutput({tag, ".protocol"}, 32'(proto_err), 32'd0);
        checkOutput({tag, ".traffic"}, 32'(any_valid), 32'(e.traffic));
        checkOutput({tag, ".err"}, 32'(obs_err), 32'(e.err));
        if (e.check_rdata) checkOutput({tag, ".rdata"}, 32'(obs_rdata), 32'(e.rdata));
        if (e.axi_read) checkOutput({tag, ".araddr"}, obs_araddr, t.a32);
        if (e.axi_write) begin
            checkOutput({tag, ".awaddr"}, obs_awaddr, t.a32);
            checkOutput({tag, ".wdata"}, obs_wdata, e.wdata);
            checkOutput({tag, ".wstrb"}, 32'(obs_wstrb), 32'(e.wstrb));
            checkOutput({tag, ".b_to_done"}, 32'(b_to_done), 32'd1);
        end
    endtask

    logic [2:0] other_types [5];
    txn_t       t;
    int         done_pulses;

    // Linear directed sequence followed by randomized traffic
    initial begin
        other_types = '{ADDR_NOT_OP, ADDR_INTERNAL_ROM, ADDR_INTERNAL_RAM, ADDR_INTERNAL_LED, ADDR_UNKNOWN};
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_is_read   = 1'b0;
        req_addr_type = 3'd0;
        req_a32       = 32'h0;
        req_d32       = 32'h0;
        req_wstrb     = 4'h0;
        clearSlave();
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.rdata", 32'(rdata), 32'h00);
        checkOutput("reset.err", 32'(err), 32'd0);
        checkOutput("reset.valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}), 32'd0);
        checkOutput("reset.araddr", bus.araddr, 32'h0);
        checkOutput("reset.awaddr", bus.awaddr, 32'h0);
        checkOutput("reset.wdata", bus.wdata, 32'h0);
        checkOutput("reset.wstrb", 32'(bus.wstrb), 32'h0);
        rst = 1'b0;

        runTransaction(mkTxn(1'b1, ADDR_AXI, 32'h4060_0002, 32'h0, 4'h0, 32'hAABB_CCDD, 2'b00), "rd_lane2");

        t = mkTxn(1'b0, ADDR_AXI, 32'h4060_0004, 32'h41, 4'h1, 32'h0, 2'b00);
        t.w_wait = 2;
        runTransaction(t, "wr_aw_first");

        runTransaction(mkTxn(1'b0, ADDR_AXI, 32'h4060_0003, 32'h5A, 4'h1, 32'h0, 2'b00), "wr_lane3");

        t = mkTxn(1'b0, ADDR_AXI, 32'h4060_0001, 32'h77, 4'h3, 32'h0, 2'b00);
        t.aw_wait = 3;
        t.b_wait  = 2;
        runTransaction(t, "wr_w_first");

        runTransaction(mkTxn(1'b1, ADDR_UNKNOWN, 32'h1234_5678, 32'h0, 4'h0, 32'h0, 2'b00), "local_unknown");
        runTransaction(mkTxn(1'b0, ADDR_AXI, 32'h4060_0008, 32'h99, 4'h0, 32'h0, 2'b00), "wr_zero_strb");

        t = mkTxn(1'b1, ADDR_AXI, 32'h4060_0011, 32'h0, 4'h0, 32'h1122_3344, 2'b10);
        t.r_wait = 1;
        runTransaction(t, "rd_slverr");

        t = mkTxn(1'b1, ADDR_AXI, 32'h4060_0010, 32'h0, 4'h0, 32'h5566_7788, 2'b00);
        t.poke = 1'b1;
        runTransaction(t, "rd_after_err");
        checkOutput("rd_after_err.err_cleared_at_accept", 32'(obs_err_first), 32'd0);

`ifdef AXI_TIMEOUT_EN
        t = mkTxn(1'b1, ADDR_AXI, 32'h4060_0020, 32'h0, 4'h0, 32'h0, 2'b00);
        t.ar_wait = 1000000;
        applyStimulus(t);
        checkOutput("timeout.latency", 32'(obs_latency), 32'(TO_CYCLES + 1));
        checkOutput("timeout.err", 32'(obs_err), 32'd1);
        checkOutput("timeout.rdata", 32'(obs_rdata), 32'hFF);
`endif

        // Reset while the read data phase is pending
        @(negedge clk);
        req_is_read   = 1'b1;
        req_addr_type = ADDR_AXI;
        req_a32       = 32'h4060_0030;
        req_valid     = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        checkOutput("rst_mid.in_rd_d", 32'(bus.rready), 32'd1);
        rst = 1'b1;
        done_pulses = 0;
        @(negedge clk);
        if (done === 1'b1) done_pulses++;
        checkOutput("rst_mid.outputs", 32'({busy, done, err, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
        checkOutput("rst_mid.rdata", 32'(rdata), 32'h00);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_pulses++;
        end
        checkOutput("rst_mid.no_done", 32'(done_pulses), 32'd0);
        checkOutput("rst_mid.idle", 32'(busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            t.is_read = 1'($urandom_range(0, 1));
            t.atype   = ($urandom_range(0, 4) == 0) ? other_types[$urandom_range(0, 4)] : ADDR_AXI;
            t.a32     = $urandom;
            t.d32     = $urandom;
            t.ws      = 4'($urandom_range(0, 15));
            t.srdata  = $urandom;
            t.resp    = 2'($urandom_range(0, 3));
            t.ar_wait = $urandom_range(0, 3);
            t.r_wait  = $urandom_range(0, 3);
            t.aw_wait = $urandom_range(0, 3);
            t.w_wait  = $urandom_range(0, 3);
            t.b_wait  = $urandom_range(0, 3);
            t.poke    = ($urandom_range(0, 5) == 0) && (t.atype == ADDR_AXI) && (t.is_read || (t.ws != 4'd0));
            runTransaction(t, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
